// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_t;

    localparam int         OVS_RATE  = 16;
    localparam logic [3:0] SMP_A     = 4'd7;
    localparam logic [3:0] SMP_B     = 4'd8;
    localparam logic [3:0] SMP_C     = 4'd9;
    localparam logic [3:0] BIT_END   = 4'd15;
    localparam int         DATA_BITS = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit.
// Empty FIFO presents zero on rdata.
module sync_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// 16x oversampled UART receiver with majority vote and byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_frontend
    import uart_rx_pkg::*;
#(
    parameter int OVS_DIV    = 68,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       resn,
    input  logic       uart_rx,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    input  logic       rx_tready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(OVS_DIV - 1);

    uart_rx_state_t state_q, state_d;

    logic                 rx_meta, rx_s;
    logic [DW-1:0]        div_q;
    logic [3:0]           s_q;
    logic                 smp_a, smp_b, bit_q;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bit_cnt;
    logic                 tick, smp_dec, bit_end, last_bit, vote;
    logic                 push, pop, frame_bad;
    logic                 fifo_full, fifo_empty;

    always_ff @(posedge sysclk) begin
        if (!resn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick     = (state_q != ST_IDLE) && (div_q == DIV_MAX);
    assign smp_dec  = tick && (s_q == SMP_C);
    assign bit_end  = tick && (s_q == BIT_END);
    assign last_bit = (bit_cnt == 3'(DATA_BITS - 1));
    assign vote     = maj3(smp_a, smp_b, rx_s);
    assign busy     = (state_q != ST_IDLE);
    assign rx_tvalid = !fifo_empty;
    assign pop      = rx_tvalid && rx_tready;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_fail;
`endif

    always_ff @(posedge sysclk) begin
        if (!resn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_fail  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: if (!rx_s) state_d = ST_START;
            ST_START: begin
                if (smp_dec && vote) state_d = ST_IDLE;
                else if (bit_end)    state_d = ST_DATA;
            end
            ST_DATA: if (bit_end && last_bit) begin
`ifdef UART_RX_PARITY_EN
                state_d = ST_PARITY;
`else
                state_d = ST_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
            // Stop decided mid-bit so the next start edge is not missed
            ST_STOP: if (smp_dec) begin
                if (vote) begin
                    state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                    par_fail = par_bad_q;
                    push     = !par_bad_q;
`else
                    push     = 1'b1;
`endif
                end else begin
                    frame_bad = 1'b1;
                    state_d   = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!resn) begin
            div_q       <= '0;
            s_q         <= '0;
            smp_a       <= 1'b1;
            smp_b       <= 1'b1;
            bit_q       <= 1'b1;
            shreg       <= '0;
            bit_cnt     <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Divider idles at zero so the bit grid starts at the edge
            if (state_q == ST_IDLE) begin
                div_q   <= '0;
                s_q     <= '0;
                bit_cnt <= '0;
            end else if (tick) begin
                div_q <= '0;
                s_q   <= s_q + 4'd1;
            end else begin
                div_q <= div_q + DW'(1);
            end
            if (tick && s_q == SMP_A) smp_a <= rx_s;
            if (tick && s_q == SMP_B) smp_b <= rx_s;
            if (smp_dec)              bit_q <= vote;
            if (state_q == ST_DATA && bit_end) begin
                shreg   <= {bit_q, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            frame_err   <= frame_bad;
            overrun_err <= push && fifo_full && !pop;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sysclk) begin
        if (!resn) begin
            par_bad_q  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state_q == ST_PARITY && bit_end)
                par_bad_q <= bit_q ^ (^shreg);
            parity_err <= par_fail;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (sysclk),
        .rst_n (resn),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .rdata (rx_tdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend with a popped-byte scoreboard.
// Sends even parity bits too when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frontend;

    localparam int OVS_DIV    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int BITP       = 16 * OVS_DIV;

    logic       sysclk = 1'b0;
    logic       resn;
    logic       uart_rx;
    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic       rx_tready;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;
    logic       busy;

    int n_checks  = 0;
    int n_errors  = 0;
    int frame_cnt = 0;
    int over_cnt  = 0;
    int par_cnt   = 0;

    logic [7:0] exp_q [$];

    uart_rx_frontend #(
        .OVS_DIV    (OVS_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sysclk      (sysclk),
        .resn        (resn),
        .uart_rx     (uart_rx),
        .rx_tdata    (rx_tdata),
        .rx_tvalid   (rx_tvalid),
        .rx_tready   (rx_tready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops and error pulse counting
    initial begin
        forever begin
            @(negedge sysclk);
            if (rx_tvalid === 1'b1 && rx_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pop_unexpected got %02h want none",
                             rx_tdata);
                end else begin
                    check("pop_data", rx_tdata, exp_q.pop_front());
                end
            end
            if (frame_err === 1'b1)   frame_cnt++;
            if (overrun_err === 1'b1) over_cnt++;
            if (parity_err === 1'b1)  par_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int p);
        uart_rx = v;
        idle(p);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_v,
                             input int p, input bit chk);
        uart_rx = 1'b0;
        if (chk) begin
            repeat (3) @(negedge sysclk);
            check("start_lat_busy_lo", busy, 0);
            @(negedge sysclk);
            check("start_lat_busy_hi", busy, 1);
            idle(p - 3);
        end else begin
            idle(p);
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d, p);
`endif
        drive_bit(stop_v, p);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 4 * BITP) begin
            idle(1);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        resn      = 1'b0;
        uart_rx   = 1'b1;
        rx_tready = 1'b1;
        idle(3);
        check("rst_tvalid",  rx_tvalid, 0);
        check("rst_tdata",   rx_tdata, 0);
        check("rst_busy",    busy, 0);
        check("rst_frame",   frame_err, 0);
        check("rst_overrun", overrun_err, 0);
        check("rst_parity",  parity_err, 0);
        resn = 1'b1;
        idle(20);

        // Single byte
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, BITP, 1'b1);
        idle(2 * BITP);
        drain("single_drain");
        check("single_frame_cnt", frame_cnt, 0);
        check("single_over_cnt", over_cnt, 0);

        // Glitch shorter than half a bit
        uart_rx = 1'b0;
        idle(5 * OVS_DIV);
        uart_rx = 1'b1;
        idle(2 * BITP);
        check("glitch_busy", busy, 0);
        check("glitch_frame_cnt", frame_cnt, 0);

        // Framing error followed by a long break
        send_byte(8'h3C, 1'b0, BITP, 1'b0);
        idle(40 * BITP);
        check("break_busy", busy, 1);
        check("break_frame_cnt", frame_cnt, 1);
        uart_rx = 1'b1;
        idle(10);
        check("break_release_busy", busy, 0);
        idle(BITP);

        // Overrun with consumer stalled
        rx_tready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1, BITP, 1'b0);
        end
        idle(BITP);
        check("overrun_cnt", over_cnt, 1);
        check("overrun_frame_cnt", frame_cnt, 1);
        check("overrun_tvalid", rx_tvalid, 1);
        check("overrun_head", rx_tdata, 8'h01);
        rx_tready = 1'b1;
        drain("overrun_drain");

        // Baud tolerance +-3%
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hFF);
        send_byte(8'h55, 1'b1, BITP - 4, 1'b0);
        send_byte(8'hFF, 1'b1, BITP - 4, 1'b0);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hFF);
        send_byte(8'h55, 1'b1, BITP + 4, 1'b0);
        send_byte(8'hFF, 1'b1, BITP + 4, 1'b0);
        idle(2 * BITP);
        drain("baud_drain");
        check("baud_frame_cnt", frame_cnt, 1);

        // Mid-frame reset flushes a held byte and aborts the frame
        rx_tready = 1'b0;
        send_byte(8'h11, 1'b1, BITP, 1'b0);
        idle(BITP);
        check("preset_tvalid", rx_tvalid, 1);
        drive_bit(1'b0, BITP);
        for (int i = 0; i < 4; i++) drive_bit(i == 0, BITP);
        drive_bit(1'b0, BITP / 2);
        check("preset_busy", busy, 1);
        resn    = 1'b0;
        uart_rx = 1'b1;
        idle(2);
        check("mreset_tvalid", rx_tvalid, 0);
        check("mreset_tdata", rx_tdata, 0);
        check("mreset_busy", busy, 0);
        resn = 1'b1;
        idle(12 * BITP);
        check("postreset_busy", busy, 0);
        check("postreset_tvalid", rx_tvalid, 0);
        rx_tready = 1'b1;
        exp_q.push_back(8'h42);
        send_byte(8'h42, 1'b1, BITP, 1'b0);
        idle(2 * BITP);
        drain("reset_drain");
        check("final_frame_cnt", frame_cnt, 1);
        check("final_over_cnt", over_cnt, 1);
        check("final_par_cnt", par_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
